systemizer_seq: RTL

Two-pass phase sequencer for the GF(2)/GF(2^m) systemizer. It drives an external `phase` engine block by block: first across the left L×L region, then optionally across the right (K−L) columns. It reports done, success and fail, and adds a watchdog so a hung phase engine cannot stall the key generator. It sits between the keygen top-level control and the `phase` instance, in place of the single-pass left-only controller.

---
 rtl/systemizer_pkg.sv | 29 ++
 rtl/systemizer_seq_if.sv | 21 ++
 rtl/systemizer_wdt.sv | 27 ++
 rtl/systemizer_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/systemizer_pkg.sv
// Shared types, op codes and size helpers for the two-pass systemizer sequencer.
package systemizer_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_IDLE = 2'b00;
  localparam logic [OP_W-1:0] OP_ELIM = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_END   = 2'd3
  } state_t;

  function automatic int unsigned nb_left(input int unsigned n, input int unsigned l);
    return (l + n - 1) / n;
  endfunction

  function automatic int unsigned nb_total(input int unsigned n, input int unsigned k);
    return (k + n - 1) / n;
  endfunction

  // Wide enough to hold NB_K, so the last block index never wraps.
  function automatic int unsigned blk_width(input int unsigned n, input int unsigned k);
    return $clog2(nb_total(n, k) + 1);
  endfunction

endpackage

// File: rtl/systemizer_seq_if.sv
// Handshake between the sequencer (master) and the phase engine (slave).
interface systemizer_seq_if #(
  parameter int unsigned BW = 5
);
  logic          phase_start;
  logic [BW-1:0] phase_block;
  logic          phase_last;
  logic          phase_partial;
  logic          phase_done;
  logic          phase_fail;

  modport master (
    output phase_start, phase_block, phase_last, phase_partial,
    input  phase_done, phase_fail
  );

  modport slave (
    input  phase_start, phase_block, phase_last, phase_partial,
    output phase_done, phase_fail
  );
endinterface

// File: rtl/systemizer_wdt.sv
// Watchdog counter: cleared on each phase start, counts while waiting, flags expiry.
module systemizer_wdt #(
  parameter int unsigned WDT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);
  localparam int unsigned CW = $clog2(WDT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Expires on the last waiting cycle so the registered fail lands WDT_CYCLES after start.
  assign expire_c = en && (cnt_q == CW'(WDT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/systemizer_seq.sv
// Two-pass phase sequencer: left L x L blocks, then optionally the right (K-L) columns.
// Define SYSTEMIZER_WDT_EN to build the phase watchdog; otherwise timeout stays 0.
module systemizer_seq
  import systemizer_pkg::*;
#(
  parameter int unsigned N          = 20,
  parameter int unsigned L          = 200,
  parameter int unsigned K          = 400,
  parameter int unsigned RIGHT_PASS = 1,
  parameter int unsigned WDT_CYCLES = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            success,
  output logic            fail,
  output logic            timeout,
  output logic [OP_W-1:0] gen_left_op,
  output logic [OP_W-1:0] gen_right_op,
  systemizer_seq_if.master ph
);
  localparam int unsigned NB_L = nb_left(N, L);
  localparam int unsigned NB_K = nb_total(N, K);
  localparam int unsigned BW   = blk_width(N, K);

  localparam logic [BW-1:0] LAST_L  = BW'(NB_L - 1);
  localparam logic [BW-1:0] LAST_K  = BW'(NB_K - 1);
  localparam logic [BW-1:0] FIRST_R = BW'(NB_L);
  localparam bit DO_RIGHT = (RIGHT_PASS != 0) && (NB_K > NB_L);
  localparam bit PART_L   = (L % N) != 0;
  localparam bit PART_K   = (K % N) != 0;

  state_t          state_q, state_d;
  logic [BW-1:0]   block_q, block_d;
  logic            busy_d, done_d, success_d, fail_d, timeout_d;
  logic            ps_d, last_d, part_d;
  logic [OP_W-1:0] lop_d, rop_d;
  logic            waiting_c, at_last_c, term_fail_c, wdt_expire_c;

  assign waiting_c   = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
  assign at_last_c   = (state_q == ST_LEFT) ? (block_q == LAST_L) : (block_q == LAST_K);
  assign term_fail_c = ph.phase_fail || wdt_expire_c;
  assign ph.phase_block = block_q;

`ifdef SYSTEMIZER_WDT_EN
  systemizer_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .clr      (ps_d),
    .en       (waiting_c),
    .expire_c (wdt_expire_c)
  );
`else
  logic unused_wdt;
  assign wdt_expire_c = 1'b0;
  assign unused_wdt   = ^WDT_CYCLES;
`endif

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    done_d    = 1'b0;
    ps_d      = 1'b0;
    success_d = success;
    fail_d    = fail;
    timeout_d = timeout;
    if (abort) begin
      state_d = ST_IDLE;
      block_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_LEFT;
            block_d   = '0;
            ps_d      = 1'b1;
            success_d = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          // Fail (engine or watchdog) wins over a coincident done; block is held.
          if (term_fail_c) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            fail_d    = 1'b1;
            timeout_d = wdt_expire_c;
          end else if (ph.phase_done) begin
            if (!at_last_c) begin
              block_d = block_q + BW'(1);
              ps_d    = 1'b1;
            end else if ((state_q == ST_LEFT) && DO_RIGHT) begin
              state_d = ST_RIGHT;
              block_d = FIRST_R;
              ps_d    = 1'b1;
            end else begin
              state_d = ST_END;
            end
          end
        end
        ST_END: begin
          state_d   = ST_IDLE;
          block_d   = '0;
          done_d    = 1'b1;
          success_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    lop_d  = (state_d == ST_LEFT)  ? OP_ELIM : OP_IDLE;
    rop_d  = (state_d == ST_RIGHT) ? OP_ELIM : OP_IDLE;
    last_d = ((state_d == ST_LEFT)  && (block_d == LAST_L)) ||
             ((state_d == ST_RIGHT) && (block_d == LAST_K));
    part_d = last_d && (((state_d == ST_LEFT) && PART_L) || ((state_d == ST_RIGHT) && PART_K));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      success          <= 1'b0;
      fail             <= 1'b0;
      timeout          <= 1'b0;
      gen_left_op      <= OP_IDLE;
      gen_right_op     <= OP_IDLE;
      ph.phase_start   <= 1'b0;
      ph.phase_last    <= 1'b0;
      ph.phase_partial <= 1'b0;
    end else begin
      busy             <= busy_d;
      done             <= done_d;
      success          <= success_d;
      fail             <= fail_d;
      timeout          <= timeout_d;
      gen_left_op      <= lop_d;
      gen_right_op     <= rop_d;
      ph.phase_start   <= ps_d;
      ph.phase_last    <= last_d;
      ph.phase_partial <= part_d;
    end
  end
endmodule
